// File: rtl/prog_divider_chain.sv
// Multi-channel programmable clock-enable divider with optional cascade between
// neighbouring channels and glitch-free ratio updates applied at terminal count.
module prog_divider_chain #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_INIT = 1,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] casc,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic                cfg_ready,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] div_out,
  output logic [CNT_W-1:0]    cycles
);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [WIDTH-1:0]    div [CHANNELS];
  logic [WIDTH-1:0]    shd [CHANNELS];
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] term;

  // Terminal counts ripple combinationally so a whole cascade fires in one cycle.
  always_comb begin
    logic prev;
    prev = 1'b0;
    ev   = '0;
    term = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      ev[k]   = en && ((k == 0) || !casc[k] || prev);
      term[k] = ev[k] && (cnt[k] == div[k]);
      prev    = term[k];
    end
  end

  // Out-of-range channel selects match nothing and are therefore always ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cfg_ch == CH_W'(k)) cfg_ready = !pend[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cnt[k] <= '0;
        div[k] <= WIDTH'(DIV_INIT);
        shd[k] <= WIDTH'(DIV_INIT);
      end
      pend    <= '0;
      tick    <= '0;
      div_out <= '0;
      cycles  <= '0;
    end else begin
      tick    <= term;
      div_out <= div_out ^ term;
      if (en) cycles <= cycles + CNT_W'(1);
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (ev[k]) cnt[k] <= term[k] ? '0 : cnt[k] + WIDTH'(1);
        if (term[k] && pend[k]) begin
          div[k]  <= shd[k];
          pend[k] <= 1'b0;
        end
        // Accept only happens with pend clear, so it never races a shadow load.
        if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(k))) begin
          shd[k]  <= cfg_div;
          pend[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_divider_chain.sv
// Scoreboard bench: per-channel terminal-count schedules are written by hand,
// merged into expected tick records, and checked by a monitor on every tick.
module tb_prog_divider_chain;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, cfg_valid, cfg_ready;
  logic [3:0]    casc, tick, div_out;
  logic [1:0]    cfg_ch;
  logic [7:0]    cfg_div;
  logic [31:0]   cycles;

  logic          rst_n_b, en_b, cfg_valid_b, cfg_ready_b;
  logic [2:0]    casc_b, tick_b, div_out_b;
  logic [1:0]    cfg_ch_b;
  logic [3:0]    cfg_div_b, cycles_b;

  always #5 clk = ~clk;

  prog_divider_chain #(.WIDTH(8), .CHANNELS(4), .DIV_INIT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .casc(casc), .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ready(cfg_ready), .tick(tick),
    .div_out(div_out), .cycles(cycles));

  prog_divider_chain #(.WIDTH(4), .CHANNELS(3), .DIV_INIT(15), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .casc(casc_b), .cfg_valid(cfg_valid_b),
    .cfg_ch(cfg_ch_b), .cfg_div(cfg_div_b), .cfg_ready(cfg_ready_b), .tick(tick_b),
    .div_out(div_out_b), .cycles(cycles_b));

  typedef struct {
    logic [3:0]  t;
    logic [3:0]  d;
    logic [31:0] c;
  } exp_t;

  exp_t        expq [$];
  int          sched [CH][$];
  logic [3:0]  par;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int ch, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) sched[ch].push_back(c);
  endtask

  // Enabled-edge count c at which a channel terminates equals the cycles output.
  task automatic build(input int last);
    for (int c = 1; c <= last; c++) begin
      logic [3:0] t;
      exp_t e;
      t = '0;
      for (int k = 0; k < CH; k++) begin
        if (sched[k].size() > 0 && sched[k][0] == c) begin
          t[k] = 1'b1;
          void'(sched[k].pop_front());
        end
      end
      if (t != '0) begin
        par ^= t;
        e.t = t;
        e.d = par;
        e.c = 32'(c);
        expq.push_back(e);
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) sched[k].delete();
    par = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic finish_test(input string name);
    en = 1'b0;
    step();
    check({name, "_drained"}, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  always @(negedge clk) begin
    if (tick !== '0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick=%b cycles=%0d, expected no tick", tick, cycles);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("tick", 32'(tick), 32'(e.t));
        check("div_out", 32'(div_out), 32'(e.d));
        check("tick_cycles", cycles, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; casc = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    rst_n_b = 1'b0; en_b = 1'b0; casc_b = '0; cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0;
    par = '0;

    // Reset state and standalone ratio 2 on every channel.
    do_reset();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_div_out", 32'(div_out), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < CH; k++) add(k, 2, 2, 10);
    build(10);
    en = 1'b1;
    repeat (10) step();
    check("cycles_after_10", cycles, 32'd10);
    finish_test("standalone");

    // Binary ripple cascade: channel k terminates every 2^(k+1) enabled edges.
    do_reset();
    casc = 4'b1110;
    for (int k = 0; k < CH; k++) add(k, 2 << k, 2 << k, 32);
    build(32);
    en = 1'b1;
    repeat (32) step();
    finish_test("cascade");

    // Ratio update on channel 2: 1 -> 3 (accepted while disabled), then 3 -> 5 mid-count.
    do_reset();
    casc = 4'b0000;
    cfg_ch = 2'd2; cfg_div = 8'd3; cfg_valid = 1'b1;
    check("upd_ready_idle", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    check("upd_ready_pend0", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < CH; k++) if (k != 2) add(k, 2, 2, 28);
    add(2, 2, 4, 10);
    add(2, 16, 6, 28);
    build(28);
    en = 1'b1;
    repeat (7) step();
    check("upd_ready_before", 32'(cfg_ready), 32'd1);
    cfg_div = 8'd5; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("upd_ready_e8", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd0; #1;
    check("upd_ready_ch0", 32'(cfg_ready), 32'd1);
    cfg_ch = 2'd2;
    step();
    check("upd_ready_e9", 32'(cfg_ready), 32'd0);
    step();
    check("upd_ready_e10", 32'(cfg_ready), 32'd1);
    repeat (18) step();
    finish_test("update");

    // Enable dropped for 7 edges after 5 enabled edges of the ripple cascade.
    do_reset();
    casc = 4'b1110;
    for (int k = 0; k < CH; k++) add(k, 2 << k, 2 << k, 32);
    build(32);
    en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    repeat (7) step();
    check("freeze_cycles", cycles, 32'd5);
    check("freeze_div_out", 32'(div_out), 32'd2);
    en = 1'b1;
    repeat (27) step();
    check("resume_cycles", cycles, 32'd32);
    finish_test("freeze");

    // Accept coinciding with term on ch1, then a pending update lost to reset.
    do_reset();
    casc = 4'b0000;
    for (int k = 0; k < CH; k++) if (k != 1) add(k, 2, 2, 14);
    add(1, 2, 2, 6);
    add(1, 14, 8, 14);
    build(15);
    en = 1'b1;
    repeat (3) step();
    cfg_ch = 2'd1; cfg_div = 8'd7; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("same_edge_ready_e4", 32'(cfg_ready), 32'd0);
    step();
    check("same_edge_ready_e5", 32'(cfg_ready), 32'd0);
    step();
    check("same_edge_ready_e6", 32'(cfg_ready), 32'd1);
    repeat (8) step();
    cfg_div = 8'd2; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("pre_rst_ready", 32'(cfg_ready), 32'd0);
    check("pre_rst_div_out", 32'(div_out), 32'hd);
    check("mid_drained", 32'(expq.size()), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_div_out", 32'(div_out), 32'd0);
    check("mid_rst_cycles", cycles, 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < CH; k++) add(k, 2, 2, 8);
    build(8);
    repeat (8) step();
    finish_test("midreset");

    // Narrow instance: divide by 16, 4-bit cycle wrap, out-of-range channel select.
    rst_n_b = 1'b0;
    step();
    rst_n_b = 1'b1;
    check("b_rst_cycles", 32'(cycles_b), 32'd0);
    en_b = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      if (e == 3) begin
        cfg_ch_b = 2'd3; cfg_div_b = 4'd0; cfg_valid_b = 1'b1;
        check("b_oor_ready", 32'(cfg_ready_b), 32'd1);
      end
      step();
      cfg_valid_b = 1'b0;
      if (e == 3) begin
        for (int k = 0; k < 3; k++) begin
          cfg_ch_b = 2'(k); #1;
          check("b_ready_after_oor", 32'(cfg_ready_b), 32'd1);
        end
      end
      check("b_tick", 32'(tick_b), (e % 16 == 0) ? 32'd7 : 32'd0);
      check("b_cycles", 32'(cycles_b), 32'(e % 16));
    end
    check("b_div_out", 32'(div_out_b), 32'd0);
    en_b = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
